tick_enable_ctrl: RTL and testbench

//  Upstream control stage for the 4-bit counter: turns two raw push-buttons into the counter's en and clear.

---
 rtl/tick_enable_ctrl.sv | 128 ++++++++++++
 tb/tb_tick_enable_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_enable_ctrl.sv
// Button conditioning plus IDLE/RUN/PAUSE control producing en/clr pulses for the 4-bit counter.
// Optional `SINGLE_STEP_EN adds btn_step: a debounced press while paused emits one en pulse.
module tick_enable_ctrl #(
  parameter int unsigned DIV        = 10,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clr,
`ifdef SINGLE_STEP_EN
  input  logic btn_step,
`endif
  output logic en,
  output logic clr,
  output logic running
);

`ifdef SINGLE_STEP_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);
  localparam logic [CW-1:0] DebMax = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q, deb_q, deb_prev_q, press;
  logic [CW-1:0]     deb_cnt_q [NumBtn];
  logic              run_press, clr_press;
  state_e            state_q;
  logic [PW-1:0]     pre_q;

  assign btn_raw[0] = btn_run;
  assign btn_raw[1] = btn_clr;
`ifdef SINGLE_STEP_EN
  assign btn_raw[2] = btn_step;
`endif

  // Debounced level only follows s2 after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NumBtn; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NumBtn; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebMax) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign press     = deb_q & ~deb_prev_q;
  assign run_press = press[0];
  assign clr_press = press[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pre_q   <= '0;
      en      <= 1'b0;
      clr     <= 1'b0;
      running <= 1'b0;
    end else begin
      en  <= 1'b0;
      clr <= 1'b0;
      if (clr_press) begin
        state_q <= StIdle;
        pre_q   <= '0;
        clr     <= 1'b1;
        running <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            pre_q <= '0;
            if (run_press) begin
              state_q <= StRun;
              running <= 1'b1;
            end
          end
          StRun: begin
            // The prescaler still advances on a pause edge so a wrap there keeps its pulse.
            if (pre_q == PreMax) begin
              pre_q <= '0;
              en    <= 1'b1;
            end else begin
              pre_q <= pre_q + PW'(1);
            end
            if (run_press) begin
              state_q <= StPause;
              running <= 1'b0;
            end
          end
          StPause: begin
            if (run_press) begin
              state_q <= StRun;
              running <= 1'b1;
            end
`ifdef SINGLE_STEP_EN
            if (press[2]) en <= 1'b1;
`endif
          end
          default: begin
            state_q <= StIdle;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_enable_ctrl.sv
// Directed bench for tick_enable_ctrl (DIV=10, DEB_CYCLES=4); en/clr pulses are scoreboarded by
// expected cycle number. Define SINGLE_STEP_EN to also exercise the step button.
module tb_tick_enable_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;
`ifdef SINGLE_STEP_EN
  logic btn_step = 1'b0;
`endif
  logic en, clr, running;

  tick_enable_ctrl #(.DIV(10), .DEB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
`ifdef SINGLE_STEP_EN
    .btn_step(btn_step),
`endif
    .en      (en),
    .clr     (clr),
    .running (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int en_q[$];
  int clr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and matched against the scoreboard.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (en === 1'b1) begin
      if (en_q.size() == 0) chk("en_unexpected", cyc, 32'hffff_ffff);
      else chk("en_cycle", cyc, en_q.pop_front());
    end else if (en_q.size() > 0 && en_q[0] < cyc) begin
      chk("en_missing", cyc, en_q.pop_front());
    end
    if (clr === 1'b1) begin
      if (clr_q.size() == 0) chk("clr_unexpected", cyc, 32'hffff_ffff);
      else chk("clr_cycle", cyc, clr_q.pop_front());
    end else if (clr_q.size() > 0 && clr_q[0] < cyc) begin
      chk("clr_missing", cyc, clr_q.pop_front());
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int t, e, r, r3, ec, e4;
`ifdef SINGLE_STEP_EN
    int r5;
`endif
    // Reset with buttons wiggling
    btn_run = 1'b1;
    tick();
    chk("rst_en", en, 0); chk("rst_clr", clr, 0); chk("rst_running", running, 0);
    btn_run = 1'b0; btn_clr = 1'b1;
    tick();
    chk("rst_en2", en, 0); chk("rst_clr2", clr, 0); chk("rst_running2", running, 0);
    btn_clr = 1'b0;
    rst = 1'b0;

    // Short glitch is ignored
    t = cyc;
    btn_run = 1'b1;
    wait_until(t + 3);
    btn_run = 1'b0;
    wait_until(t + 20);
    chk("glitch_running", running, 0);

    // Run press: running at E+6, en at E+16/26/36
    t = cyc; e = t + 1; r = e + 6;
    btn_run = 1'b1;
    en_q.push_back(r + 10); en_q.push_back(r + 20); en_q.push_back(r + 30);
    wait_until(r - 1);
    chk("run_before", running, 0);
    wait_until(r);
    chk("run_rise", running, 1);
    wait_until(e + 11);
    btn_run = 1'b0;

    // Pause when prescaler becomes 3
    wait_until(r + 26);
    btn_run = 1'b1;
    wait_until(r + 31);
    btn_run = 1'b0;
    wait_until(r + 32);
    chk("pause_before", running, 1);
    wait_until(r + 33);
    chk("pause_fall", running, 0);
    wait_until(r + 50);
    chk("pause_hold", running, 0);

    // Resume: next en 7 cycles later
    wait_until(r + 52);
    btn_run = 1'b1;
    r3 = r + 59;
    en_q.push_back(r3 + 7);
    wait_until(r + 57);
    btn_run = 1'b0;
    wait_until(r3);
    chk("resume_rise", running, 1);

    // clr and run pressed together: clr wins
    wait_until(r3 + 8);
    btn_run = 1'b1; btn_clr = 1'b1;
    ec = r3 + 9;
    clr_q.push_back(ec + 6);
    wait_until(r3 + 13);
    btn_run = 1'b0; btn_clr = 1'b0;
    wait_until(ec + 5);
    chk("both_before", running, 1);
    wait_until(ec + 6);
    chk("both_idle", running, 0);
    wait_until(ec + 40);
    chk("both_stays_idle", running, 0);

    // clr while already idle still pulses
    t = cyc;
    btn_clr = 1'b1;
    clr_q.push_back(t + 7);
    wait_until(t + 5);
    btn_clr = 1'b0;
    wait_until(t + 20);

    // rst mid-RUN with btn_run held: re-debounced after reset
    t = cyc; e4 = t + 1;
    btn_run = 1'b1;
    wait_until(e4 + 6);
    chk("rr_run", running, 1);
    wait_until(e4 + 12);
    rst = 1'b1;
    wait_until(e4 + 13);
    chk("rr_en", en, 0); chk("rr_clr", clr, 0); chk("rr_running", running, 0);
    wait_until(e4 + 14);
    rst = 1'b0;
    en_q.push_back(e4 + 31);
    wait_until(e4 + 20);
    chk("rr_before", running, 0);
    wait_until(e4 + 21);
    chk("rr_rise", running, 1);
    btn_run = 1'b0;
    wait_until(e4 + 32);
    btn_clr = 1'b1;
    clr_q.push_back(e4 + 39);
    wait_until(e4 + 37);
    btn_clr = 1'b0;
    wait_until(e4 + 39);
    chk("rr_idle", running, 0);
    wait_until(e4 + 45);

`ifdef SINGLE_STEP_EN
    // Step while paused gives one en; step while running gives none
    t = cyc; r5 = t + 7;
    btn_run = 1'b1;
    en_q.push_back(r5 + 10);
    wait_until(t + 5);
    btn_run = 1'b0;
    wait_until(r5 + 8);
    btn_run = 1'b1;
    wait_until(r5 + 13);
    btn_run = 1'b0;
    wait_until(r5 + 15);
    chk("st_paused", running, 0);
    wait_until(r5 + 20);
    btn_step = 1'b1;
    en_q.push_back(r5 + 27);
    wait_until(r5 + 25);
    btn_step = 1'b0;
    wait_until(r5 + 35);
    btn_run = 1'b1;
    en_q.push_back(r5 + 47); en_q.push_back(r5 + 57);
    wait_until(r5 + 40);
    btn_run = 1'b0;
    wait_until(r5 + 42);
    chk("st_resume", running, 1);
    wait_until(r5 + 44);
    btn_step = 1'b1;
    wait_until(r5 + 49);
    btn_step = 1'b0;
    wait_until(r5 + 58);
    btn_clr = 1'b1;
    clr_q.push_back(r5 + 65);
    wait_until(r5 + 63);
    btn_clr = 1'b0;
    wait_until(r5 + 80);
    chk("st_idle", running, 0);
`endif

    chk("en_queue_drained", en_q.size(), 0);
    chk("clr_queue_drained", clr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
